// File: rtl/cnn_mul_share_arb_if.sv
// Request/result bundle for cnn_mul_share_arb: per-requester operand handshake,
// tagged product return channel and pipeline occupancy flag.
interface cnn_mul_share_arb_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*10-1:0] req_a;
   logic [NUM_REQ*14-1:0] req_b;
   logic                  res_valid;
   logic                  res_ready;
   logic [23:0]           res_data;
   logic [ID_W-1:0]       res_id;
   logic                  busy;

   // master: requesters plus result consumer; slave: the arbiter
   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_data, res_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_data, res_id, busy
   );
endinterface

// File: rtl/cnn_mul_share_arb.sv
// Round-robin sharing of one signed 10x14 multiplier among NUM_REQ requesters.
// Optional CNN_MUL_ARB_OUTREG_EN adds one output register stage after the multiply.
module cnn_mul_share_arb #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ID_W       = 2,
   parameter int unsigned MUL_STAGES = 2
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   cnn_mul_share_arb_if.slave bus
);

   localparam int unsigned A_W  = 10;
   localparam int unsigned B_W  = 14;
   localparam int unsigned P_W  = 24;
   localparam int unsigned LAST = MUL_STAGES - 1;

   logic                  pipe_en;
   logic                  xfer;
   logic                  found;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       grant_id;
   logic [ID_W-1:0]       ptr;
   logic signed [A_W-1:0] sel_a;
   logic signed [B_W-1:0] sel_b;

   logic                  op_valid;
   logic signed [A_W-1:0] op_a;
   logic signed [B_W-1:0] op_b;
   logic [ID_W-1:0]       op_id;
   logic signed [P_W-1:0] prod;

   logic [MUL_STAGES-1:0] m_valid;
   logic signed [P_W-1:0] m_data [MUL_STAGES];
   logic [ID_W-1:0]       m_id   [MUL_STAGES];

   logic                  res_valid;
   logic [P_W-1:0]        res_data;
   logic [ID_W-1:0]       res_id;
   logic                  busy;

   // Grant search: indices above the pointer first, then wrap to those at or below it
   always_comb begin
      grant    = '0;
      grant_id = '0;
      sel_a    = '0;
      sel_b    = '0;
      found    = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!found && (i > int'(ptr)) && bus.req_valid[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            grant_id = ID_W'(i);
            sel_a    = bus.req_a[i*A_W +: A_W];
            sel_b    = bus.req_b[i*B_W +: B_W];
         end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!found && (i <= int'(ptr)) && bus.req_valid[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            grant_id = ID_W'(i);
            sel_a    = bus.req_a[i*A_W +: A_W];
            sel_b    = bus.req_b[i*B_W +: B_W];
         end
      end
   end

   assign pipe_en       = !(res_valid && !bus.res_ready);
   assign bus.req_ready = (ap_rst || !pipe_en) ? '0 : grant;
   assign xfer          = |(bus.req_valid & bus.req_ready);

   // Operand capture stage and round-robin pointer
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_id    <= '0;
         ptr      <= ID_W'(NUM_REQ - 1);
      end else if (pipe_en) begin
         op_valid <= xfer;
         if (xfer) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_id <= grant_id;
            ptr   <= grant_id;
         end
      end
   end

   // Full-width signed product: both operands sign-extended to 24 bits before multiplying
   assign prod = P_W'(op_a) * P_W'(op_b);

   // Multiply pipeline; data registers only load behind a valid entry
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         m_valid <= '0;
         for (int s = 0; s < int'(MUL_STAGES); s++) begin
            m_data[s] <= '0;
            m_id[s]   <= '0;
         end
      end else if (pipe_en) begin
         m_valid[0] <= op_valid;
         if (op_valid) begin
            m_data[0] <= prod;
            m_id[0]   <= op_id;
         end
         for (int s = 1; s < int'(MUL_STAGES); s++) begin
            m_valid[s] <= m_valid[s-1];
            if (m_valid[s-1]) begin
               m_data[s] <= m_data[s-1];
               m_id[s]   <= m_id[s-1];
            end
         end
      end
   end

`ifdef CNN_MUL_ARB_OUTREG_EN
   logic           o_valid;
   logic [P_W-1:0] o_data;
   logic [ID_W-1:0] o_id;

   // Extra output register, stalled by the same pipe_en as the multiply stages
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_id    <= '0;
      end else if (pipe_en) begin
         o_valid <= m_valid[LAST];
         if (m_valid[LAST]) begin
            o_data <= m_data[LAST];
            o_id   <= m_id[LAST];
         end
      end
   end

   assign res_valid = o_valid;
   assign res_data  = o_data;
   assign res_id    = o_id;
   assign busy      = op_valid | (|m_valid) | o_valid;
`else
   assign res_valid = m_valid[LAST];
   assign res_data  = m_data[LAST];
   assign res_id    = m_id[LAST];
   assign busy      = op_valid | (|m_valid);
`endif

   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_data;
   assign bus.res_id    = res_id;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Directed self-checking bench for cnn_mul_share_arb (latency follows CNN_MUL_ARB_OUTREG_EN).
module tb_cnn_mul_share_arb;

   localparam int unsigned NR = 4;
   localparam int unsigned IW = 2;
   localparam int unsigned MS = 2;
`ifdef CNN_MUL_ARB_OUTREG_EN
   localparam int LAT = MS + 1;
`else
   localparam int LAT = MS;
`endif

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   int   n_cmp  = 0;
   int   n_err  = 0;

   always #5 ap_clk = ~ap_clk;

   cnn_mul_share_arb_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

   cnn_mul_share_arb #(.NUM_REQ(NR), .ID_W(IW), .MUL_STAGES(MS)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      bus.req_a[i*10 +: 10] = 10'(a);
      bus.req_b[i*14 +: 14] = 14'(b);
   endtask

   function automatic logic [23:0] mul(input int a, input int b);
      return 24'(a * b);
   endfunction

   // Waits up to maxw cycles for a result, checks it, then advances one cycle
   task automatic expect_res(input string tag, input logic [23:0] d, input int id, input int maxw);
      int w = 0;
      while (!bus.res_valid && w < maxw) begin
         tick();
         w++;
      end
      chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
      chk({tag, "_data"},  32'(bus.res_data),  32'(d));
      chk({tag, "_id"},    32'(bus.res_id),    32'(id));
      tick();
   endtask

   task automatic do_reset;
      ap_rst = 1'b1;
      tick();
      tick();
      ap_rst = 1'b0;
   endtask

   logic [23:0] rr_exp [4];
   int          t4_a   [6];
   int          t4_b   [6];

   initial begin
      #100000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rr_exp[0] = 24'hFFFFEB;   //    7 *   -3 = -21
      rr_exp[1] = 24'hFFB1E0;   // -100 *  200 = -20000
      rr_exp[2] = 24'hFC1BE8;   //  255 * -1000 = -255000
      rr_exp[3] = 24'h000001;   //   -1 *   -1 = 1
      for (int k = 0; k < 6; k++) begin
         t4_a[k] = 40 * k - 200;
         t4_b[k] = 1500 - 700 * k;
      end

      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b1;

      // Reset state, with requests pending that must not be accepted
      ap_rst        = 1'b1;
      bus.req_valid = 4'hF;
      tick();
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_data",  32'(bus.res_data),  32'd0);
      chk("rst_id",    32'(bus.res_id),    32'd0);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      bus.req_valid = '0;
      ap_rst        = 1'b0;
      tick();

      // Test 1: single op, exact latency
      set_op(0, -3, 100);
      bus.req_valid = 4'b0001;
      #1 chk("t1_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = '0;
      chk("t1_busy", 32'(bus.busy), 32'd1);
      for (int c = 1; c <= LAT; c++) begin
         tick();
         if (c < LAT) begin
            chk("t1_early", 32'(bus.res_valid), 32'd0);
         end else begin
            chk("t1_valid", 32'(bus.res_valid), 32'd1);
            chk("t1_data",  32'(bus.res_data),  32'h00FFFED4);
            chk("t1_id",    32'(bus.res_id),    32'd0);
         end
      end
      tick();
      chk("t1_drain", 32'(bus.res_valid), 32'd0);
      chk("t1_idle",  32'(bus.busy),      32'd0);

      // Test 2: operand extremes, back-to-back from one persistent requester
      set_op(0, -512, -8192);
      bus.req_valid = 4'b0001;
      tick();
      set_op(0, 511, 8191);
      #1 chk("t2_persist", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = '0;
      expect_res("t2_min", 24'h400000, 0, LAT);
      expect_res("t2_max", 24'h3FDE01, 0, 0);

      // Test 3: all requesters continuously valid, rotation and gapless results
      do_reset();
      set_op(0, 7, -3);
      set_op(1, -100, 200);
      set_op(2, 255, -1000);
      set_op(3, -1, -1);
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               bus.req_valid = 4'hF;
               #1 chk("t3_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
               tick();
            end
            bus.req_valid = '0;
         end
         begin
            expect_res("t3_r", rr_exp[0], 0, LAT + 2);
            for (int k = 1; k < 8; k++) expect_res("t3_r", rr_exp[k % 4], k % 4, 0);
         end
      join
      chk("t3_drain", 32'(bus.res_valid), 32'd0);

      // Test 4: stream from requester 2 with a 3-cycle consumer stall
      fork
         begin
            int k = 0;
            int guard = 0;
            logic acc;
            bus.req_valid = 4'b0100;
            while (k < 6 && guard < 40) begin
               set_op(2, t4_a[k], t4_b[k]);
               #1 acc = bus.req_ready[2];
               tick();
               if (acc) k++;
               guard++;
            end
            bus.req_valid = '0;
            chk("t4_issued", 32'(k), 32'd6);
         end
         begin
            int w = 0;
            while (!bus.res_valid && w < 20) begin
               tick();
               w++;
            end
            chk("t4_first_valid", 32'(bus.res_valid), 32'd1);
            chk("t4_first_data",  32'(bus.res_data),  32'(mul(t4_a[0], t4_b[0])));
            chk("t4_first_id",    32'(bus.res_id),    32'd2);
            bus.res_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               chk("t4_hold_valid", 32'(bus.res_valid), 32'd1);
               chk("t4_hold_data",  32'(bus.res_data),  32'(mul(t4_a[0], t4_b[0])));
               chk("t4_hold_id",    32'(bus.res_id),    32'd2);
               chk("t4_stall_rdy",  32'(bus.req_ready), 32'd0);
            end
            bus.res_ready = 1'b1;
            tick();
            for (int k = 1; k < 6; k++) expect_res("t4_r", mul(t4_a[k], t4_b[k]), 2, 0);
            chk("t4_drain", 32'(bus.res_valid), 32'd0);
         end
      join

      // Test 5: reset with two ops in flight
      set_op(1, 9, 9);
      bus.req_valid = 4'b0010;
      tick();
      tick();
      bus.req_valid = 4'hF;
      ap_rst        = 1'b1;
      #1 chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("t5_valid", 32'(bus.res_valid), 32'd0);
      chk("t5_busy",  32'(bus.busy),      32'd0);
      ap_rst        = 1'b0;
      bus.req_valid = '0;
      for (int c = 0; c <= LAT; c++) begin
         tick();
         chk("t5_no_ghost", 32'(bus.res_valid), 32'd0);
      end
      set_op(0, -3, 100);
      bus.req_valid = 4'hF;
      #1 chk("t5_grant0", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = '0;
      expect_res("t5_after", 24'hFFFED4, 0, LAT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
